// File: rtl/hyperbus_cfg_pkg.sv
// rtl/hyperbus_cfg_pkg.sv - shared types and default table for the HyperBus boot-time register sequencer
package hyperbus_cfg_pkg;

    localparam int unsigned REG_AW = 32;
    localparam int unsigned REG_DW = 32;

    typedef struct packed {
        logic [REG_AW-1:0]   addr;
        logic                write;
        logic [REG_DW-1:0]   wdata;
        logic [REG_DW/8-1:0] wstrb;
        logic                valid;
    } hb_reg_req_t;

    typedef struct packed {
        logic [REG_DW-1:0] rdata;
        logic              error;
        logic              ready;
    } hb_reg_rsp_t;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [REG_DW-1:0] data;
    } cfg_entry_t;

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_WRITE,
        ST_READ,
        ST_DONE
    } cfg_state_e;

    // Standard two-chip setup: timing and latency first, chip address map last.
    localparam int unsigned CFG_DEFAULT_NUM = 4;
    localparam logic [CFG_DEFAULT_NUM-1:0][REG_AW-1:0] CFG_DEFAULT_ADDR = {
        32'h0000_001C, 32'h0000_0018, 32'h0000_0008, 32'h0000_0004
    };
    localparam logic [CFG_DEFAULT_NUM-1:0][REG_DW-1:0] CFG_DEFAULT_DATA = {
        32'h0100_0000, 32'h0000_0000, 32'h0000_0006, 32'h0000_0C35
    };

endpackage

// File: rtl/hyperbus_cfg_rom.sv
// rtl/hyperbus_cfg_rom.sv - combinational lookup of the compile-time configuration table
module hyperbus_cfg_rom
    import hyperbus_cfg_pkg::*;
#(
    parameter int unsigned NumCfg       = CFG_DEFAULT_NUM,
    parameter int unsigned RegAddrWidth = REG_AW,
    parameter int unsigned RegDataWidth = REG_DW,
    parameter int unsigned IdxW         = (NumCfg > 1) ? $clog2(NumCfg) : 1,
    parameter logic [NumCfg-1:0][RegAddrWidth-1:0] CfgAddr = '0,
    parameter logic [NumCfg-1:0][RegDataWidth-1:0] CfgData = '0
) (
    input  logic [IdxW-1:0] i_idx,
    output cfg_entry_t      o_entry
);

    // Indices past the table end read as zero rather than out-of-range.
    always_comb begin
        o_entry = '0;
        for (int i = 0; i < int'(NumCfg); i++) begin
            if (i_idx == IdxW'(i)) begin
                o_entry.addr = REG_AW'(CfgAddr[i]);
                o_entry.data = REG_DW'(CfgData[i]);
            end
        end
    end

endmodule

// File: rtl/hyperbus_cfg_seq.sv
// rtl/hyperbus_cfg_seq.sv - boot-time HyperBus register sequencer; HYPERBUS_CFG_READBACK_EN adds write readback
module hyperbus_cfg_seq
    import hyperbus_cfg_pkg::*;
#(
    parameter int unsigned RegAddrWidth = REG_AW,
    parameter int unsigned RegDataWidth = REG_DW,
    parameter type         reg_req_t    = hb_reg_req_t,
    parameter type         reg_rsp_t    = hb_reg_rsp_t,
    parameter int unsigned NumCfg       = CFG_DEFAULT_NUM,
    parameter logic [NumCfg-1:0][RegAddrWidth-1:0] CfgAddr = '0,
    parameter logic [NumCfg-1:0][RegDataWidth-1:0] CfgData = '0,
    parameter int unsigned StartDelay   = 300*200,
    parameter int unsigned MaxRetries   = 3
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     restart_i,
    input  reg_req_t reg_req_i,
    output reg_rsp_t reg_rsp_o,
    output reg_req_t reg_req_o,
    input  reg_rsp_t reg_rsp_i,
    output logic     busy_o,
    output logic     done_o,
    output logic     error_o
);

    localparam int unsigned IdxW = (NumCfg > 1) ? $clog2(NumCfg) : 1;
    localparam int unsigned CntW = (StartDelay > 0) ? $clog2(StartDelay + 1) : 1;
    localparam int unsigned RtyW = (MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumCfg - 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(StartDelay);
    localparam logic [RtyW-1:0] RtyMax  = RtyW'(MaxRetries);

    cfg_state_e      r_state, w_state_d;
    logic [IdxW-1:0] r_idx, w_idx_d;
    logic [RtyW-1:0] r_retry, w_retry_d;
    logic [CntW-1:0] r_cnt, w_cnt_d;
    logic            r_error, w_error_d;
    logic            r_restart_pend, w_pend_d;
    reg_req_t        r_req, w_req_d;
    cfg_entry_t      w_entry;
    logic            w_hs;
    logic            w_advance;
    logic            w_done;

    // Looked up by the next index so the request register loads the entry it is about to issue.
    hyperbus_cfg_rom #(
        .NumCfg       (NumCfg),
        .RegAddrWidth (RegAddrWidth),
        .RegDataWidth (RegDataWidth),
        .IdxW         (IdxW),
        .CfgAddr      (CfgAddr),
        .CfgData      (CfgData)
    ) u_rom (
        .i_idx   (w_idx_d),
        .o_entry (w_entry)
    );

    assign w_hs = r_req.valid && reg_rsp_i.ready;

    always_comb begin
        w_state_d = r_state;
        w_idx_d   = r_idx;
        w_retry_d = r_retry;
        w_cnt_d   = r_cnt;
        w_error_d = r_error;
        w_pend_d  = r_restart_pend;
        w_advance = 1'b0;
        unique case (r_state)
            ST_WAIT: begin
                if (r_cnt == CntMax) begin
                    w_state_d = ST_WRITE;
                    w_idx_d   = '0;
                    w_retry_d = '0;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            ST_WRITE: begin
                if (w_hs) begin
                    if (reg_rsp_i.error) begin
                        if (r_retry < RtyMax) begin
                            w_retry_d = r_retry + 1'b1;
                        end else begin
                            w_error_d = 1'b1;
                            w_advance = 1'b1;
                        end
                    end else begin
`ifdef HYPERBUS_CFG_READBACK_EN
                        w_state_d = ST_READ;
`else
                        w_advance = 1'b1;
`endif
                    end
                end
            end
`ifdef HYPERBUS_CFG_READBACK_EN
            ST_READ: begin
                if (w_hs) begin
                    if (reg_rsp_i.error || (reg_rsp_i.rdata != r_req.wdata)) begin
                        if (r_retry < RtyMax) begin
                            w_retry_d = r_retry + 1'b1;
                            w_state_d = ST_WRITE;
                        end else begin
                            w_error_d = 1'b1;
                            w_advance = 1'b1;
                        end
                    end else begin
                        w_advance = 1'b1;
                    end
                end
            end
`endif
            ST_DONE: begin
                // A restart never cuts off a host transfer in flight; it waits for an idle cycle.
                if ((restart_i || r_restart_pend) && !reg_req_i.valid) begin
                    w_state_d = ST_WAIT;
                    w_cnt_d   = '0;
                    w_idx_d   = '0;
                    w_retry_d = '0;
                    w_error_d = 1'b0;
                    w_pend_d  = 1'b0;
                end else if (restart_i) begin
                    w_pend_d = 1'b1;
                end
            end
            default: w_state_d = ST_WAIT;
        endcase

        if (w_advance) begin
            if (r_idx == LastIdx) begin
                w_state_d = ST_DONE;
            end else begin
                w_idx_d   = r_idx + 1'b1;
                w_retry_d = '0;
                w_state_d = ST_WRITE;
            end
        end

        w_req_d = '0;
        if ((w_state_d == ST_WRITE) || (w_state_d == ST_READ)) begin
            w_req_d.valid = 1'b1;
            w_req_d.write = (w_state_d == ST_WRITE);
            w_req_d.addr  = w_entry.addr;
            w_req_d.wdata = w_entry.data;
            w_req_d.wstrb = '1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state        <= ST_WAIT;
            r_idx          <= '0;
            r_retry        <= '0;
            r_cnt          <= '0;
            r_error        <= 1'b0;
            r_restart_pend <= 1'b0;
            r_req          <= '0;
        end else begin
            r_state        <= w_state_d;
            r_idx          <= w_idx_d;
            r_retry        <= w_retry_d;
            r_cnt          <= w_cnt_d;
            r_error        <= w_error_d;
            r_restart_pend <= w_pend_d;
            r_req          <= w_req_d;
        end
    end

    assign w_done  = (r_state == ST_DONE);
    assign done_o  = w_done;
    assign busy_o  = !w_done;
    assign error_o = r_error;

    always_comb begin
        reg_req_o = w_done ? reg_req_i : r_req;
        reg_rsp_o = w_done ? reg_rsp_i : '0;
    end

endmodule

// File: tb/tb_hyperbus_cfg_seq.sv
// tb/tb_hyperbus_cfg_seq.sv - directed vector bench for hyperbus_cfg_seq
module tb_hyperbus_cfg_seq;
    import hyperbus_cfg_pkg::*;

    localparam int unsigned N  = 3;
    localparam int unsigned SD = 10;
    localparam int unsigned MR = 3;
    localparam logic [N-1:0][31:0] ADDRS = {32'h30, 32'h20, 32'h10};
    localparam logic [N-1:0][31:0] DATAS = {32'hC2, 32'hB1, 32'hA0};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        restart = 1'b0;
    hb_reg_req_t host_req, dut_req, host_wr;
    hb_reg_rsp_t host_rsp, dut_rsp;
    logic        busy, done, err;

    logic        slv_ready = 1'b1;
    logic [31:0] slv_err_addr = 32'hFFFF_FFFF;
    int          slv_err_cnt = 0;
    logic [31:0] slv_bad_addr = 32'hFFFF_FFFF;
    int          slv_bad_cnt = 0;

    int checks = 0;
    int errors = 0;
    int cyc = -1;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic        write;
    } hs_t;
    hs_t log_q[$];

    typedef struct {
        int          cyc;
        logic        hvalid;
        logic        exp_valid;
        logic        exp_write;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic        exp_rsp_ready;
        logic        exp_busy;
        logic        exp_done;
        logic        exp_err;
    } vec_t;
    vec_t tbl[10];

    hyperbus_cfg_seq #(
        .NumCfg     (N),
        .CfgAddr    (ADDRS),
        .CfgData    (DATAS),
        .StartDelay (SD),
        .MaxRetries (MR)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .restart_i (restart),
        .reg_req_i (host_req),
        .reg_rsp_o (host_rsp),
        .reg_req_o (dut_req),
        .reg_rsp_i (dut_rsp),
        .busy_o    (busy),
        .done_o    (done),
        .error_o   (err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        logic [31:0] d;
        d = '0;
        for (int i = 0; i < int'(N); i++) if (ADDRS[i] == a) d = DATAS[i];
        return d;
    endfunction

    always_comb begin
        dut_rsp       = '0;
        dut_rsp.ready = slv_ready;
        dut_rsp.error = dut_req.valid && dut_req.write && (dut_req.addr == slv_err_addr) && (slv_err_cnt > 0);
        dut_rsp.rdata = rd_model(dut_req.addr);
        if (!dut_req.write && (dut_req.addr == slv_bad_addr) && (slv_bad_cnt > 0)) dut_rsp.rdata = 32'hDEAD;
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Records the handshake visible this cycle, then advances to the next negedge.
    task automatic step();
        logic hs_err, hs_bad;
        hs_err = 1'b0;
        hs_bad = 1'b0;
        if (dut_req.valid && dut_rsp.ready) begin
            log_q.push_back(hs_t'{cyc: cyc, addr: dut_req.addr, write: dut_req.write});
            hs_err = dut_rsp.error;
            hs_bad = !dut_req.write && (dut_req.addr == slv_bad_addr) && (slv_bad_cnt > 0);
        end
        @(negedge clk);
        cyc++;
        if (hs_err) slv_err_cnt--;
        if (hs_bad) slv_bad_cnt--;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        restart  = 1'b0;
        host_req = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc   = -1;
        log_q.delete();
    endtask

    task automatic run_until_done(input int budget, output int done_cyc);
        for (int k = 0; k < budget && !done; k++) step();
        #1;
        chk1("done_within_budget", done, 1'b1);
        done_cyc = cyc;
    endtask

    function automatic int count_hs(input logic [31:0] a, input logic w);
        int n;
        n = 0;
        foreach (log_q[i]) if (log_q[i].addr == a && log_q[i].write == w) n++;
        return n;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

    initial begin
        int r;
        int dc;
        host_wr       = '0;
        host_wr.addr  = 32'h8;
        host_wr.write = 1'b1;
        host_wr.wdata = 32'h55;
        host_wr.wstrb = 4'hF;
        host_wr.valid = 1'b1;
        host_req      = '0;

        tbl[0] = '{-1, 1'b0, 1'b0, 1'b0, 32'h00, 32'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{ 0, 1'b0, 1'b0, 1'b0, 32'h00, 32'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{ 2, 1'b1, 1'b0, 1'b0, 32'h00, 32'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{ 9, 1'b1, 1'b0, 1'b0, 32'h00, 32'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{10, 1'b1, 1'b1, 1'b1, 32'h10, 32'hA0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{11, 1'b1, 1'b1, 1'b1, 32'h20, 32'hB1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{12, 1'b1, 1'b1, 1'b1, 32'h30, 32'hC2, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{13, 1'b1, 1'b1, 1'b1, 32'h08, 32'h55, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[8] = '{14, 1'b0, 1'b0, 1'b0, 32'h00, 32'h00, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[9] = '{15, 1'b0, 1'b0, 1'b0, 32'h00, 32'h00, 1'b1, 1'b0, 1'b1, 1'b0};

        do_reset();

`ifdef HYPERBUS_CFG_READBACK_EN
        slv_bad_addr = 32'h30;
        slv_bad_cnt  = 1;
        run_until_done(80, dc);
        chk32("rb_writes_e2", 32'(count_hs(32'h30, 1'b1)), 32'd2);
        chk32("rb_reads_e2", 32'(count_hs(32'h30, 1'b0)), 32'd2);
        chk32("rb_reads_e0", 32'(count_hs(32'h10, 1'b0)), 32'd1);
        chk1("rb_error", err, 1'b0);
`else
        for (int i = 0; i < 10; i++) begin
            while (cyc < tbl[i].cyc) step();
            host_req = tbl[i].hvalid ? host_wr : '0;
            #1;
            chk1 ("req_valid", dut_req.valid, tbl[i].exp_valid);
            chk1 ("req_write", dut_req.write, tbl[i].exp_write);
            chk32("req_addr", dut_req.addr, tbl[i].exp_addr);
            chk32("req_wdata", dut_req.wdata, tbl[i].exp_wdata);
            chk1 ("host_rsp_ready", host_rsp.ready, tbl[i].exp_rsp_ready);
            chk1 ("busy", busy, tbl[i].exp_busy);
            chk1 ("done", done, tbl[i].exp_done);
            chk1 ("error", err, tbl[i].exp_err);
        end
        chk32("first_run_hs_count", 32'(log_q.size()), 32'd4);
        if (log_q.size() == 4) begin
            chk32("hs0_cyc", 32'(log_q[0].cyc), 32'd10);
            chk32("hs1_addr", log_q[1].addr, 32'h20);
            chk32("hs2_cyc", 32'(log_q[2].cyc), 32'd12);
            chk32("hs3_host_addr", log_q[3].addr, 32'h8);
            chk32("hs3_cyc", 32'(log_q[3].cyc), 32'd13);
        end

        // restart held off by an active host request, with entry 1 failing twice
        host_req = host_wr;
        restart  = 1'b1;
        step();
        restart  = 1'b0;
        #1;
        chk1 ("defer_done", done, 1'b1);
        chk32("defer_passthru_addr", dut_req.addr, 32'h8);
        step();
        #1;
        chk1("defer_done_2", done, 1'b1);
        host_req     = '0;
        slv_err_addr = 32'h20;
        slv_err_cnt  = 2;
        step();
        #1;
        chk1("restart_done_low", done, 1'b0);
        chk1("restart_busy", busy, 1'b1);
        r = cyc;
        log_q.delete();
        for (int k = 0; k < 40 && !dut_req.valid; k++) step();
        chk32("restart_first_valid_cyc", 32'(cyc), 32'(r + 11));
        run_until_done(60, dc);
        chk32("retry_done_cyc", 32'(dc), 32'(r + 16));
        chk32("retry_e1_writes", 32'(count_hs(32'h20, 1'b1)), 32'd3);
        chk32("retry_e0_writes", 32'(count_hs(32'h10, 1'b1)), 32'd1);
        chk1 ("retry_error", err, 1'b0);

        // reset asserted mid-transfer aborts at once
        do_reset();
        while (cyc < 10) step();
        #1;
        chk1("pre_abort_valid", dut_req.valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("abort_valid", dut_req.valid, 1'b0);
        chk1("abort_busy", busy, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = -1;
        log_q.delete();

        // entry 0 exhausts its retries
        slv_err_addr = 32'h10;
        slv_err_cnt  = 4;
        run_until_done(60, dc);
        chk32("exhaust_done_cyc", 32'(dc), 32'd16);
        chk32("exhaust_e0_writes", 32'(count_hs(32'h10, 1'b1)), 32'd4);
        chk32("exhaust_e2_writes", 32'(count_hs(32'h30, 1'b1)), 32'd1);
        chk1 ("exhaust_error", err, 1'b1);
        restart = 1'b1;
        step();
        restart = 1'b0;
        #1;
        chk1("restart_clears_error", err, 1'b0);
        chk1("restart_clears_done", done, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
